// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller poll scheduler.
// Optional feature macro used by the scheduler: GC_POLL_RUMBLE_EN.
package gc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_TX_WAIT = 2'd2,
      ST_RX_WAIT = 2'd3
   } gc_state_e;

   localparam int GC_STATUS_W = 64;
   localparam int GC_CMD_W    = 24;
   localparam int ERR_CNT_W   = 8;

   localparam logic [GC_CMD_W-1:0] GC_CMD_POLL = 24'h400300;

   // Error counter sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gc_interval_timer.sv
// Poll pacing counter: counts 0..PERIOD-1 while enabled and emits a one-cycle
// registered pulse on each wrap. Held at zero while disabled.
module gc_interval_timer #(
   parameter logic [31:0] PERIOD = 32'd600000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic due
);

   logic [31:0] cnt_q, cnt_d;
   logic        due_q, due_d;

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      due_d = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == PERIOD - 32'd1) begin
         cnt_d = '0;
         due_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         due_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         due_q <= due_d;
      end
   end

   assign due = due_q;

endmodule

// File: rtl/gc_poll_sched.sv
// Periodic GameCube controller poll scheduler: send poll command, then capture
// the 64-bit status or time out. GC_POLL_RUMBLE_EN adds a rumble input bit.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | waiting for poll_due
//   ST_SEND    | tx_start/tx_cmd presented for one cycle
//   ST_TX_WAIT | transmitter busy, waiting for tx_done
//   ST_RX_WAIT | rx_arm high, waiting for rx_valid or timeout
module gc_poll_sched
   import gc_pkg::*;
#(
   parameter logic [31:0]         POLL_PERIOD = 32'd600000,
   parameter logic [31:0]         RX_TIMEOUT  = 32'd50000,
   parameter logic [GC_CMD_W-1:0] POLL_CMD    = GC_CMD_POLL
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
`ifdef GC_POLL_RUMBLE_EN
   input  logic                   rumble,
`endif
   output logic [GC_CMD_W-1:0]    tx_cmd,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   rx_arm,
   input  logic                   rx_valid,
   input  logic [GC_STATUS_W-1:0] rx_data,
   output logic [GC_STATUS_W-1:0] status,
   output logic                   status_valid,
   output logic                   timeout_err,
   output logic                   missed_poll,
   output logic [ERR_CNT_W-1:0]   err_count,
   output logic                   busy
);

   logic                   poll_due;
   logic [GC_CMD_W-1:0]    cmd_word;

   gc_state_e              state_q;
   logic [31:0]            tmo_q;
   logic [GC_CMD_W-1:0]    tx_cmd_q;
   logic                   tx_start_q;
   logic                   rx_arm_q;
   logic [GC_STATUS_W-1:0] status_q;
   logic                   status_valid_q;
   logic                   timeout_err_q;
   logic                   missed_poll_q;
   logic [ERR_CNT_W-1:0]   err_count_q;
   logic                   busy_q;

   gc_interval_timer #(.PERIOD(POLL_PERIOD)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .due    (poll_due)
   );

`ifdef GC_POLL_RUMBLE_EN
   assign cmd_word = {POLL_CMD[GC_CMD_W-1:1], rumble};
`else
   assign cmd_word = POLL_CMD;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         tmo_q          <= '0;
         tx_cmd_q       <= '0;
         tx_start_q     <= 1'b0;
         rx_arm_q       <= 1'b0;
         status_q       <= '0;
         status_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         missed_poll_q  <= 1'b0;
         err_count_q    <= '0;
         busy_q         <= 1'b0;
      end else begin
         tx_start_q     <= 1'b0;
         status_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         // A poll arriving mid-transaction is dropped, only flagged.
         missed_poll_q  <= poll_due && (state_q != ST_IDLE);

         case (state_q)
            ST_IDLE: begin
               if (poll_due) begin
                  state_q    <= ST_SEND;
                  tx_start_q <= 1'b1;
                  tx_cmd_q   <= cmd_word;
                  busy_q     <= 1'b1;
               end
            end
            ST_SEND: begin
               state_q  <= ST_TX_WAIT;
               tx_cmd_q <= '0;
            end
            ST_TX_WAIT: begin
               if (tx_done) begin
                  state_q  <= ST_RX_WAIT;
                  tmo_q    <= '0;
                  rx_arm_q <= 1'b1;
               end
            end
            ST_RX_WAIT: begin
               // rx_valid has priority over a coincident timeout.
               if (rx_valid) begin
                  state_q        <= ST_IDLE;
                  status_q       <= rx_data;
                  status_valid_q <= 1'b1;
                  rx_arm_q       <= 1'b0;
                  busy_q         <= 1'b0;
               end else if (tmo_q == RX_TIMEOUT - 32'd1) begin
                  state_q       <= ST_IDLE;
                  timeout_err_q <= 1'b1;
                  err_count_q   <= sat_inc(err_count_q);
                  rx_arm_q      <= 1'b0;
                  busy_q        <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_cmd       = tx_cmd_q;
   assign tx_start     = tx_start_q;
   assign rx_arm       = rx_arm_q;
   assign status       = status_q;
   assign status_valid = status_valid_q;
   assign timeout_err  = timeout_err_q;
   assign missed_poll  = missed_poll_q;
   assign err_count    = err_count_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_gc_poll_sched.sv
// Bench for gc_poll_sched: reactive TX/RX responder with random latencies and
// data, event log from the DUT, expectations computed from poll timing arithmetic.
`timescale 1ns/1ps
module tb_gc_poll_sched;

   localparam int P  = 100;
   localparam int T  = 30;
   localparam int NK = 11;
   localparam int K_TXS = 0, K_CMD = 1, K_ARMU = 2, K_ARMD = 3, K_BUSYU = 4, K_BUSYD = 5,
                  K_SV = 6, K_SVD = 7, K_TO = 8, K_ERR = 9, K_MISS = 10;

   logic        clk = 1'b0;
   logic        reset, enable, tx_done, rx_valid;
   logic [63:0] rx_data;
   logic [23:0] tx_cmd;
   logic        tx_start, rx_arm, status_valid, timeout_err, missed_poll, busy;
   logic [63:0] status;
   logic [7:0]  err_count;
   logic [23:0] exp_cmd;
`ifdef GC_POLL_RUMBLE_EN
   logic        rumble;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   longint      cyc      = 0;
   logic [63:0] exp_status;
   int          exp_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gc_poll_sched #(.POLL_PERIOD(32'd100), .RX_TIMEOUT(32'd30)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
`ifdef GC_POLL_RUMBLE_EN
      .rumble       (rumble),
`endif
      .tx_cmd       (tx_cmd),
      .tx_start     (tx_start),
      .tx_done      (tx_done),
      .rx_arm       (rx_arm),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .status       (status),
      .status_valid (status_valid),
      .timeout_err  (timeout_err),
      .missed_poll  (missed_poll),
      .err_count    (err_count),
      .busy         (busy)
   );

   // ---------------- event log, sampled on the falling edge ----------------
   logic [63:0] evq [NK][$];
   logic        arm_p = 1'b0, busy_p = 1'b0;

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin evq[K_TXS].push_back(64'(cyc)); evq[K_CMD].push_back({40'd0, tx_cmd}); end
      if (rx_arm === 1'b1 && !arm_p) evq[K_ARMU].push_back(64'(cyc));
      if (rx_arm === 1'b0 && arm_p)  evq[K_ARMD].push_back(64'(cyc));
      if (busy === 1'b1 && !busy_p)  evq[K_BUSYU].push_back(64'(cyc));
      if (busy === 1'b0 && busy_p)   evq[K_BUSYD].push_back(64'(cyc));
      if (status_valid === 1'b1) begin evq[K_SV].push_back(64'(cyc)); evq[K_SVD].push_back(status); end
      if (timeout_err === 1'b1) begin evq[K_TO].push_back(64'(cyc)); evq[K_ERR].push_back({56'd0, err_count}); end
      if (missed_poll === 1'b1) evq[K_MISS].push_back(64'(cyc));
      arm_p  = (rx_arm === 1'b1);
      busy_p = (busy === 1'b1);
   end

   function automatic logic [63:0] pop_ev(input int k);
      if (evq[k].size() == 0) return '1;
      return evq[k].pop_front();
   endfunction

   // ---------------- transmitter / receiver responder ----------------
   typedef struct {
      longint      s;
      int          t;
      int          r;
      logic [63:0] d;
   } poll_t;
   poll_t       log_q[$];

   int          resp_mode = 0;
   int          fix_t = 10, fix_r = 20;
   logic [63:0] fix_d = 64'h0080_8080_8080_0000;
   bit          stray_on = 1'b0;

   initial begin
      longint      tx_at, rx_at;
      int          cur_r, t, r;
      logic [63:0] cur_d, d;
      bit          resp_idle;
      tx_at = -1; rx_at = -1; cur_r = -1; cur_d = '0; resp_idle = 1'b1;
      tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0;
      forever begin
         @(posedge clk); #1;
         tx_done  = 1'b0;
         rx_valid = 1'b0;
         if (tx_start === 1'b1) begin
            if (resp_mode == 1) begin
               t = $urandom_range(20, 1);
               r = $urandom_range(T - 1, 0);
               d = {$urandom, $urandom};
            end else begin
               t = fix_t; r = fix_r; d = fix_d;
            end
            log_q.push_back('{cyc, t, r, d});
            tx_at = cyc + t; rx_at = -1; cur_r = r; cur_d = d; resp_idle = 1'b0;
         end
         if (cyc == tx_at) begin
            tx_done = 1'b1; tx_at = -1;
            if (cur_r >= 0) rx_at = cyc + 1 + cur_r;
         end
         if (cyc == rx_at) begin
            rx_valid = 1'b1; rx_data = cur_d; rx_at = -1; resp_idle = 1'b1;
         end else if (stray_on && resp_idle && $urandom_range(3, 0) == 0) begin
            if ($urandom_range(1, 0) == 1) tx_done = 1'b1;
            else begin rx_valid = 1'b1; rx_data = {$urandom, $urandom}; end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_all();
      for (int k = 0; k < NK; k++) evq[k].delete();
      log_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; enable = 1'b0;
      tick(3);
      n_checks++; if (tx_start !== 1'b0)      begin n_fail++; $display("FAIL reset tx_start: got %b want 0", tx_start); end
      n_checks++; if (tx_cmd !== 24'h0)       begin n_fail++; $display("FAIL reset tx_cmd: got %h want 0", tx_cmd); end
      n_checks++; if (rx_arm !== 1'b0)        begin n_fail++; $display("FAIL reset rx_arm: got %b want 0", rx_arm); end
      n_checks++; if (status !== 64'h0)       begin n_fail++; $display("FAIL reset status: got %h want 0", status); end
      n_checks++; if (status_valid !== 1'b0)  begin n_fail++; $display("FAIL reset status_valid: got %b want 0", status_valid); end
      n_checks++; if (timeout_err !== 1'b0)   begin n_fail++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
      n_checks++; if (missed_poll !== 1'b0)   begin n_fail++; $display("FAIL reset missed_poll: got %b want 0", missed_poll); end
      n_checks++; if (err_count !== 8'd0)     begin n_fail++; $display("FAIL reset err_count: got %0d want 0", err_count); end
      n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      reset = 1'b0;
      tick(2);
      exp_status = '0;
      exp_err    = 0;
   endtask

   // n polls with responses that always fit inside one period
   task automatic test_polls(input string nm, input int n);
      longint      c0, s_exp, arm_exp, end_exp;
      poll_t       p;
      logic [63:0] got;
      clear_all();
      c0 = cyc; enable = 1'b1;
      tick(P * n + 70);
      enable = 1'b0;
      tick(5);
      n_checks++; if (log_q.size() != n) begin n_fail++; $display("FAIL %s poll count: got %0d want %0d", nm, log_q.size(), n); end
      for (int k = 0; k < n && log_q.size() > 0; k++) begin
         p = log_q.pop_front();
         s_exp = c0 + longint'(P) * (k + 1) + 1;
         n_checks++; if (p.s != s_exp) begin n_fail++; $display("FAIL %s tx_start cycle #%0d: got %0d want %0d", nm, k, p.s, s_exp); end
         got = pop_ev(K_CMD);
         n_checks++; if (got !== {40'd0, exp_cmd}) begin n_fail++; $display("FAIL %s tx_cmd #%0d: got %h want %h", nm, k, got, exp_cmd); end
         got = pop_ev(K_BUSYU);
         n_checks++; if (got !== 64'(s_exp)) begin n_fail++; $display("FAIL %s busy rise #%0d: got %0d want %0d", nm, k, got, s_exp); end
         arm_exp = s_exp + p.t + 1;
         got = pop_ev(K_ARMU);
         n_checks++; if (got !== 64'(arm_exp)) begin n_fail++; $display("FAIL %s rx_arm rise #%0d: got %0d want %0d", nm, k, got, arm_exp); end
         if (p.r >= 0 && p.r < T) begin
            end_exp = arm_exp + p.r + 1;
            exp_status = p.d;
            got = pop_ev(K_SV);
            n_checks++; if (got !== 64'(end_exp)) begin n_fail++; $display("FAIL %s status_valid cycle #%0d: got %0d want %0d", nm, k, got, end_exp); end
            got = pop_ev(K_SVD);
            n_checks++; if (got !== p.d) begin n_fail++; $display("FAIL %s status data #%0d: got %h want %h", nm, k, got, p.d); end
         end else begin
            end_exp = arm_exp + T;
            if (exp_err < 255) exp_err++;
            got = pop_ev(K_TO);
            n_checks++; if (got !== 64'(end_exp)) begin n_fail++; $display("FAIL %s timeout_err cycle #%0d: got %0d want %0d", nm, k, got, end_exp); end
            got = pop_ev(K_ERR);
            n_checks++; if (got !== 64'(exp_err)) begin n_fail++; $display("FAIL %s err_count #%0d: got %0d want %0d", nm, k, got, exp_err); end
         end
         got = pop_ev(K_ARMD);
         n_checks++; if (got !== 64'(end_exp)) begin n_fail++; $display("FAIL %s rx_arm fall #%0d: got %0d want %0d", nm, k, got, end_exp); end
         got = pop_ev(K_BUSYD);
         n_checks++; if (got !== 64'(end_exp)) begin n_fail++; $display("FAIL %s busy fall #%0d: got %0d want %0d", nm, k, got, end_exp); end
      end
      n_checks++; if (evq[K_SV].size() + evq[K_TO].size() + evq[K_MISS].size() != 0) begin
         n_fail++; $display("FAIL %s extra events: got sv=%0d to=%0d miss=%0d want 0", nm, evq[K_SV].size(), evq[K_TO].size(), evq[K_MISS].size()); end
      n_checks++; if (status !== exp_status) begin n_fail++; $display("FAIL %s final status: got %h want %h", nm, status, exp_status); end
      n_checks++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL %s final err_count: got %0d want %0d", nm, err_count, exp_err); end
   endtask

   task automatic test_missed();
      longint      c0;
      logic [63:0] got;
      clear_all();
      fix_t = 150; fix_r = 20; fix_d = {$urandom, $urandom};
      c0 = cyc; enable = 1'b1;
      tick(340);
      enable = 1'b0;
      tick(160);
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c0 + 101)) begin n_fail++; $display("FAIL missed first tx_start: got %0d want %0d", got, c0 + 101); end
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c0 + 301)) begin n_fail++; $display("FAIL missed next tx_start: got %0d want %0d", got, c0 + 301); end
      n_checks++; if (evq[K_TXS].size() != 0) begin n_fail++; $display("FAIL missed extra tx_start: got %0d want 0", evq[K_TXS].size()); end
      got = pop_ev(K_MISS);
      n_checks++; if (got !== 64'(c0 + 201)) begin n_fail++; $display("FAIL missed pulse cycle: got %0d want %0d", got, c0 + 201); end
      n_checks++; if (evq[K_MISS].size() != 0) begin n_fail++; $display("FAIL missed pulse count: got %0d extra want 0", evq[K_MISS].size()); end
      got = pop_ev(K_SV);
      n_checks++; if (got !== 64'(c0 + 273)) begin n_fail++; $display("FAIL missed status_valid 1: got %0d want %0d", got, c0 + 273); end
      got = pop_ev(K_SV);
      n_checks++; if (got !== 64'(c0 + 473)) begin n_fail++; $display("FAIL missed status_valid 2: got %0d want %0d", got, c0 + 473); end
      n_checks++; if (status !== fix_d) begin n_fail++; $display("FAIL missed status: got %h want %h", status, fix_d); end
      exp_status = fix_d;
      fix_t = 10;
   endtask

   task automatic test_enable_drop();
      longint      c0, c1;
      logic [63:0] got;
      clear_all();
      fix_t = 10; fix_r = 20; fix_d = {$urandom, $urandom};
      c0 = cyc; enable = 1'b1;
      tick(115);
      n_checks++; if (rx_arm !== 1'b1) begin n_fail++; $display("FAIL endrop rx_arm before drop: got %b want 1", rx_arm); end
      enable = 1'b0;
      tick(285);
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c0 + 101)) begin n_fail++; $display("FAIL endrop tx_start: got %0d want %0d", got, c0 + 101); end
      n_checks++; if (evq[K_TXS].size() != 0) begin n_fail++; $display("FAIL endrop tx_start after disable: got %0d want 0", evq[K_TXS].size()); end
      got = pop_ev(K_SV);
      n_checks++; if (got !== 64'(c0 + 133)) begin n_fail++; $display("FAIL endrop status_valid: got %0d want %0d", got, c0 + 133); end
      n_checks++; if (status !== fix_d) begin n_fail++; $display("FAIL endrop status: got %h want %h", status, fix_d); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop busy idle: got %b want 0", busy); end
      exp_status = fix_d;
      c1 = cyc; enable = 1'b1;
      tick(P + 61);
      enable = 1'b0;
      tick(10);
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c1 + P + 1)) begin n_fail++; $display("FAIL endrop re-enable tx_start: got %0d want %0d", got, c1 + P + 1); end
   endtask

   task automatic test_reset_mid();
      longint      c0, c1;
      logic [63:0] got;
      clear_all();
      fix_t = 10; fix_r = -1;
      c0 = cyc; enable = 1'b1;
      tick(117);
      n_checks++; if (rx_arm !== 1'b1) begin n_fail++; $display("FAIL rstmid rx_arm before reset: got %b want 1", rx_arm); end
      n_checks++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL rstmid err_count before reset: got %0d want %0d", err_count, exp_err); end
      reset = 1'b1; enable = 1'b0;
      tick(1);
      n_checks++; if (status !== 64'h0)      begin n_fail++; $display("FAIL rstmid status: got %h want 0", status); end
      n_checks++; if (err_count !== 8'd0)    begin n_fail++; $display("FAIL rstmid err_count: got %0d want 0", err_count); end
      n_checks++; if (rx_arm !== 1'b0)       begin n_fail++; $display("FAIL rstmid rx_arm: got %b want 0", rx_arm); end
      n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rstmid busy: got %b want 0", busy); end
      n_checks++; if (tx_start !== 1'b0 || tx_cmd !== 24'h0) begin n_fail++; $display("FAIL rstmid tx: got start=%b cmd=%h want 0", tx_start, tx_cmd); end
      n_checks++; if (status_valid !== 1'b0 || timeout_err !== 1'b0 || missed_poll !== 1'b0) begin
         n_fail++; $display("FAIL rstmid pulses: got sv=%b to=%b miss=%b want 0", status_valid, timeout_err, missed_poll); end
      reset = 1'b0;
      exp_err = 0; exp_status = '0;
      tick(60);
      n_checks++; if (evq[K_TO].size() != 0) begin n_fail++; $display("FAIL rstmid timeout after reset: got %0d want 0", evq[K_TO].size()); end
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c0 + 101)) begin n_fail++; $display("FAIL rstmid first tx_start: got %0d want %0d", got, c0 + 101); end
      c1 = cyc; enable = 1'b1;
      tick(P + 6);
      got = pop_ev(K_TXS);
      n_checks++; if (got !== 64'(c1 + P + 1)) begin n_fail++; $display("FAIL rstmid restart tx_start: got %0d want %0d", got, c1 + P + 1); end
      enable = 1'b0;
      tick(60);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0;
`ifdef GC_POLL_RUMBLE_EN
      rumble  = 1'b1;
      exp_cmd = 24'h400301;
`else
      exp_cmd = 24'h400300;
`endif
      test_reset();
      test_polls("fixed", 3);
      resp_mode = 1; stray_on = 1'b1;
      test_polls("random", 20);
      resp_mode = 0; stray_on = 1'b0;
      fix_t = 10; fix_r = T - 1; fix_d = {$urandom, $urandom};
      test_polls("rx_on_timeout", 2);
      fix_r = T; fix_d = {$urandom, $urandom};
      test_polls("rx_after_timeout", 1);
      test_missed();
      test_enable_drop();
      fix_t = 10; fix_r = -1;
      test_polls("timeout_sat", 260);
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gc_poll_sched.md
Name: gc_poll_sched

Overview:
Scheduler that sequences periodic GameCube controller poll transactions over the shared single-wire serial link. An interval counter paces the polls. For each poll the block commands the serial transmitter to send the 24-bit poll command, then arms the receiver and waits for the 64-bit status or a timeout. It sits between the top-level game logic (which consumes status) and the gc serial TX/RX engines (which are clocked by the divided bit clock).

Parameters:
POLL_PERIOD, 32'd600000, clk cycles between poll-due pulses (6 ms at 100 MHz).
RX_TIMEOUT, 32'd50000, clk cycles allowed in RX_WAIT before abort.
POLL_CMD, 24'h400300, command word driven on tx_cmd.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  polling enabled
tx_cmd  out  24  command to transmitter, valid while tx_start high
tx_start  out  1  one-cycle start pulse to transmitter
tx_done  in  1  one-cycle pulse from transmitter, command fully sent
rx_arm  out  1  level, high while receiver should capture
rx_valid  in  1  one-cycle pulse, rx_data valid
rx_data  in  64  controller status from receiver
status  out  64  last good status
status_valid  out  1  one-cycle pulse when status updates
timeout_err  out  1  one-cycle pulse on RX timeout
missed_poll  out  1  one-cycle pulse when poll-due arrives while not IDLE
err_count  out  8  saturating timeout count
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (clk and reset only): FSM=IDLE; all outputs 0 (status=64'h0, err_count=0, tx_cmd=0); interval and timeout counters=0.
- Interval counter, 32-bit: when enable=0, held at 0. When enable=1, increments and wraps to 0 at POLL_PERIOD-1. poll_due pulses on the wrap cycle, so the first poll is due POLL_PERIOD cycles after enable rises.
- FSM states: IDLE, SEND, TX_WAIT, RX_WAIT.
- IDLE: poll_due -> SEND.
- SEND: tx_start=1 and tx_cmd=POLL_CMD for exactly one cycle -> TX_WAIT.
- TX_WAIT: tx_done -> RX_WAIT; timeout counter cleared. There is no timeout in this state; the transmitter always completes.
- RX_WAIT: rx_arm=1; timeout counter increments each cycle.
  - rx_valid: status<=rx_data; status_valid pulses on the cycle after rx_valid; -> IDLE.
  - Otherwise, at timeout counter==RX_TIMEOUT-1: timeout_err pulse; err_count+1, saturating at 255; -> IDLE.
  - rx_valid and timeout in the same cycle: rx_valid wins, no error.
- Registered outputs: tx_start, rx_arm and busy are registered. rx_arm falls on the cycle the FSM leaves RX_WAIT.
- poll_due outside IDLE: the poll is dropped (not queued), and missed_poll pulses.
- enable deasserted mid-transaction: the current transaction completes normally, then the FSM stays in IDLE.
- Stray inputs: tx_done outside TX_WAIT and rx_valid outside RX_WAIT are ignored.
- Latency, poll_due to tx_start: 1 cycle.
- status holds its value across timeouts.

Optional Feature:
GC_POLL_RUMBLE_EN.
- Defined: adds input port rumble (1 bit). tx_cmd = {POLL_CMD[23:1], rumble}, with rumble sampled in IDLE on the poll_due cycle and held through SEND.
- Undefined: no rumble port; tx_cmd = POLL_CMD.

Decomposition:
- Package gc_pkg holds:
  - FSM state typedef (2-bit enum)
  - GC_CMD_POLL = 24'h400300
  - GC_STATUS_W = 64, GC_CMD_W = 24
  - ERR_CNT_W = 8
- Sub-module gc_interval_timer (params PERIOD; ports clk, reset, enable, due) produces poll_due. It has the same counter structure as the team's clock divider, but outputs a one-cycle pulse instead of a square wave.

Test Plan:
- POLL_PERIOD=100, enable=1 at t0: tx_start pulses at t0+101, t0+201, … with tx_cmd=24'h400300. Transmitter model returns tx_done after 10 cycles; rx_valid with 64'h0080_8080_8080_0000 after 20 cycles. Expect status equal to that value and status_valid pulsing exactly 1 cycle after rx_valid; busy low between polls.
- RX_TIMEOUT=30, rx_valid never asserted: timeout_err pulses 30 cycles after RX_WAIT entry, rx_arm drops the same cycle, err_count increments per poll. Over 300 polls err_count saturates at 255; status unchanged.
- rx_valid on exactly the timeout cycle: status_valid pulses; no timeout_err; err_count unchanged.
- TX response delayed 150 cycles with POLL_PERIOD=100: missed_poll pulses once at the next poll_due; the next tx_start occurs only on the following due pulse.
- Drop enable during RX_WAIT, then deliver rx_valid: status updates, FSM goes to IDLE, no further tx_start. Reassert enable: first tx_start arrives POLL_PERIOD+1 cycles later.
- Assert reset mid-RX_WAIT: next cycle all outputs are 0 including status and err_count. With GC_POLL_RUMBLE_EN and rumble=1, tx_cmd=24'h400301.
